// File: rtl/antirrebote_pkg.sv
// Shared definitions for the antirrebote button debouncer: FSM state encoding,
// default timing constants and a helper used to size the shared counter.
package antirrebote_pkg;

  // Defaults assume a 50 MHz clock: 10 ms debounce, 0.5 s repeat delay, 0.1 s repeat period.
  localparam int unsigned DEF_DB_CYCLES  = 500000;
  localparam int unsigned DEF_RPT_DELAY  = 25000000;
  localparam int unsigned DEF_RPT_PERIOD = 5000000;
  localparam bit          DEF_RPT_EN     = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    DB_PRESS,
    HELD,
    REPEAT,
    DB_RELEASE
  } estado_t;

  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sincronizador.sv
// Two-flop synchronizer that brings the raw asynchronous button into the clk domain.
module sincronizador (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: sequential state always uses non-blocking assignments so both flops
  // sample on the same edge and the chain really is two stages deep.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/antirrebote.sv
// Button debouncer with optional auto-repeat: emits one registered pulse per
// accepted press and, while held, periodic repeat pulses.
module antirrebote
  import antirrebote_pkg::*;
#(
  parameter int unsigned DB_CYCLES  = DEF_DB_CYCLES,
  parameter int unsigned RPT_DELAY  = DEF_RPT_DELAY,
  parameter int unsigned RPT_PERIOD = DEF_RPT_PERIOD,
  parameter bit          RPT_EN     = DEF_RPT_EN
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic pulse,
  output logic pressed,
  output logic repeating
);

  localparam int CNT_W = $clog2(max3(DB_CYCLES, RPT_DELAY, RPT_PERIOD)) + 1;

  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(RPT_DELAY - 1);
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(RPT_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // With a count of 1 or 0 the terminal compares collapse and pulses could abut.
  if (DB_CYCLES < 2 || RPT_DELAY < 2 || RPT_PERIOD < 2) begin : g_param_check
    $error("antirrebote: DB_CYCLES, RPT_DELAY and RPT_PERIOD must all be >= 2");
  end

  logic             sync;
  estado_t          estado;
  logic [CNT_W-1:0] cnt;

  sincronizador u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn_in),
    .q   (sync)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      estado    <= IDLE;
      cnt       <= '0;
      pulse     <= 1'b0;
      pressed   <= 1'b0;
      repeating <= 1'b0;
    end else begin
      // NOTE: the strobe defaults low every cycle, so each branch below only has
      // to raise it; nothing needs to remember to drop it afterwards.
      pulse <= 1'b0;
      case (estado)
        IDLE: begin
          if (sync) begin
            estado <= DB_PRESS;
            cnt    <= '0;
          end
        end

        DB_PRESS: begin
          if (!sync) begin
            estado <= IDLE;
            cnt    <= '0;
          end else if (cnt == DB_LAST) begin
            estado  <= HELD;
            cnt     <= '0;
            pulse   <= 1'b1;
            pressed <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        HELD: begin
          if (!sync) begin
            estado <= DB_RELEASE;
            cnt    <= '0;
          end else if (RPT_EN && cnt == DLY_LAST) begin
            estado    <= REPEAT;
            cnt       <= '0;
            pulse     <= 1'b1;
            repeating <= 1'b1;
          end else if (cnt != DLY_LAST) begin
            // Without auto-repeat the count parks at the delay limit instead of wrapping.
            cnt <= cnt + CNT_ONE;
          end
        end

        REPEAT: begin
          if (!sync) begin
            estado    <= DB_RELEASE;
            cnt       <= '0;
            repeating <= 1'b0;
          end else if (cnt == PER_LAST) begin
            cnt   <= '0;
            pulse <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        DB_RELEASE: begin
          if (sync) begin
            estado <= HELD;
            cnt    <= '0;
          end else if (cnt == DB_LAST) begin
            estado  <= IDLE;
            cnt     <= '0;
            pressed <= 1'b0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        default: begin
          estado    <= IDLE;
          cnt       <= '0;
          pressed   <= 1'b0;
          repeating <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_antirrebote.sv
// Scoreboard bench for antirrebote: one instance with auto-repeat, one without,
// sharing clock, reset and button; expected pulse edges are queued per instance.
module tb_antirrebote;

  localparam int DB  = 4;
  localparam int DLY = 20;
  localparam int PER = 8;
  localparam int LAT = DB + 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic btn = 1'b0;

  logic pulse_a, pressed_a, repeating_a;
  logic pulse_b, pressed_b, repeating_b;

  int cyc      = 0;
  int checks   = 0;
  int failures = 0;
  int exp_a[$];
  int exp_b[$];

  antirrebote #(
    .DB_CYCLES  (DB),
    .RPT_DELAY  (DLY),
    .RPT_PERIOD (PER),
    .RPT_EN     (1'b1)
  ) dut_a (
    .clk       (clk),
    .rst       (rst),
    .btn_in    (btn),
    .pulse     (pulse_a),
    .pressed   (pressed_a),
    .repeating (repeating_a)
  );

  antirrebote #(
    .DB_CYCLES  (DB),
    .RPT_DELAY  (DLY),
    .RPT_PERIOD (PER),
    .RPT_EN     (1'b0)
  ) dut_b (
    .clk       (clk),
    .rst       (rst),
    .btn_in    (btn),
    .pulse     (pulse_b),
    .pressed   (pressed_b),
    .repeating (repeating_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Drive the button on a falling edge; e0 is the first rising edge that samples it.
  task automatic drive(input logic v, output int e0);
    @(negedge clk);
    btn = v;
    e0  = cyc + 1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Keep the button high for exactly n sampling edges starting at e0.
  task automatic release_at(input int e0, input int n);
    wait_until(e0 + n - 1);
    btn = 1'b0;
  endtask

  task automatic settle(input string tag);
    repeat (14) @(negedge clk);
    check({tag, "_pressed_a"}, pressed_a, 1'b0);
    check({tag, "_pressed_b"}, pressed_b, 1'b0);
    check({tag, "_repeating_a"}, repeating_a, 1'b0);
    check({tag, "_pending_a"}, exp_a.size(), 0);
    check({tag, "_pending_b"}, exp_b.size(), 0);
    exp_a.delete();
    exp_b.delete();
  endtask

  always @(negedge clk) begin
    if (pulse_a === 1'b1) begin
      if (exp_a.size() == 0) check("a_unexpected_pulse", pulse_a, 1'b0);
      else                   check("a_pulse_edge", cyc, exp_a.pop_front());
      check("a_pressed_with_pulse", pressed_a, 1'b1);
    end
  end

  always @(negedge clk) begin
    if (pulse_b === 1'b1) begin
      if (exp_b.size() == 0) check("b_unexpected_pulse", pulse_b, 1'b0);
      else                   check("b_pulse_edge", cyc, exp_b.pop_front());
      check("b_pressed_with_pulse", pressed_b, 1'b1);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int e0;
    int t;
    int r;

    rst = 1'b0;
    btn = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_pulse_a", pulse_a, 1'b0);
    check("rst_pressed_a", pressed_a, 1'b0);
    check("rst_repeating_a", repeating_a, 1'b0);
    check("rst_pulse_b", pulse_b, 1'b0);
    check("rst_pressed_b", pressed_b, 1'b0);
    check("rst_repeating_b", repeating_b, 1'b0);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    check("idle_pressed_a", pressed_a, 1'b0);

    // Clean press held for 10 cycles.
    drive(1'b1, e0);
    t = e0 + LAT;
    exp_a.push_back(t);
    exp_b.push_back(t);
    wait_until(t - 1);
    check("clean_pressed_early", pressed_a, 1'b0);
    check("clean_pulse_early", pulse_a, 1'b0);
    wait_until(t);
    check("clean_pulse_level", pulse_a, 1'b1);
    wait_until(t + 1);
    check("clean_pulse_drops", pulse_a, 1'b0);
    release_at(e0, 10);
    settle("clean");

    // Bounce: toggles every 2 cycles for 20 cycles, then stays high.
    for (int i = 0; i < 20; i++) drive((i % 4) < 2, e0);
    check("bounce_no_press", pressed_a, 1'b0);
    drive(1'b1, e0);
    t = e0 + LAT;
    exp_a.push_back(t);
    exp_b.push_back(t);
    release_at(e0, 12);
    settle("bounce");

    // Auto-repeat: held 60 cycles.
    drive(1'b1, e0);
    t = e0 + LAT;
    exp_a.push_back(t);
    exp_a.push_back(t + DLY);
    for (int k = 1; k <= 4; k++) exp_a.push_back(t + DLY + k * PER);
    exp_b.push_back(t);
    wait_until(t + DLY - 1);
    check("rpt_repeating_early", repeating_a, 1'b0);
    wait_until(t + DLY);
    check("rpt_repeating_a", repeating_a, 1'b1);
    check("rpt_repeating_b", repeating_b, 1'b0);
    check("rpt_pressed_b", pressed_b, 1'b1);
    release_at(e0, 60);
    wait_until(e0 + 62);
    check("rpt_repeating_b_late", repeating_b, 1'b0);
    settle("rpt");

    // Release glitch: two low cycles while HELD.
    drive(1'b1, e0);
    t = e0 + LAT;
    exp_a.push_back(t);
    exp_b.push_back(t);
    wait_until(t + 3);
    btn = 1'b0;
    repeat (2) @(negedge clk);
    btn = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("glitch_pressed_a", pressed_a, 1'b1);
    end
    check("glitch_pressed_b", pressed_b, 1'b1);
    btn = 1'b0;
    settle("glitch");

    // Reset three cycles into REPEAT, button still held.
    drive(1'b1, e0);
    t = e0 + LAT;
    exp_a.push_back(t);
    exp_a.push_back(t + DLY);
    exp_b.push_back(t);
    wait_until(t + DLY + 3);
    check("pre_rst_repeating_a", repeating_a, 1'b1);
    rst = 1'b0;
    #1;
    check("midrst_pulse_a", pulse_a, 1'b0);
    check("midrst_pressed_a", pressed_a, 1'b0);
    check("midrst_repeating_a", repeating_a, 1'b0);
    check("midrst_pressed_b", pressed_b, 1'b0);
    repeat (3) @(negedge clk);
    check("midrst_pending_a", exp_a.size(), 0);
    rst = 1'b1;
    r = cyc + 1;
    exp_a.push_back(r + LAT);
    exp_b.push_back(r + LAT);
    wait_until(r + LAT - 1);
    check("post_rst_pressed_early", pressed_a, 1'b0);
    wait_until(r + LAT);
    check("post_rst_pressed", pressed_a, 1'b1);
    release_at(r, 12);
    settle("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
